alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the combinational execute-stage ALU of the ARM core.
- Adds width generality, an internal status register (NZCV) with per-op flag update, an iterative shift-add multiplier, and a valid/ready handshake.
- Sits between the ID/EX register and the EX/MEM register. The hazard unit stalls on in_ready=0.

Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4.
- CNT_W, $clog2(WIDTH)+1, multiplier iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation this cycle
- alu_cmd  in  4  command code, see Behaviour
- s_bit  in  1  1 = operation updates the status register
- val1  in  WIDTH  operand 1 (Rn)
- val2  in  WIDTH  operand 2 (shifter output)
- out_valid  out  1  result register holds an undelivered result
- out_ready  in  1  downstream accepts the result
- alu_out  out  WIDTH  result
- sr  out  4  status register {Z,C,N,V}

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State=IDLE; out_valid=0, alu_out=0, sr=4'b0000, counter=0.
  - in_ready=0 while rst_n=0.
  - A multiply in progress is abandoned with no output.
- Command codes:
  - MOV 0001 → val2
  - MVN 1001 → ~val2
  - ADD 0010 → val1+val2 (also used for CMN/LDR/STR address)
  - ADC 0011 → val1+val2+C
  - SUB 0100 → val1−val2 (also CMP)
  - SBC 0101 → val1−val2−!C
  - AND 0110 → val1&val2 (also TST)
  - ORR 0111 → val1|val2
  - EOR 1000 → val1^val2
  - MUL 1010 → low WIDTH bits of val1×val2
  - Any other code → result 0, flags follow the logical rule below.
- Arithmetic is computed at WIDTH+1 bits.
  - Add: C = carry out; V = (a[MSB]==b[MSB]) & (r[MSB]!=a[MSB]).
  - Subtract: C = NOT borrow (ARM convention; 5−3 gives C=1, 3−5 gives C=0); V = (a[MSB]!=b[MSB]) & (r[MSB]!=a[MSB]).
- Flags:
  - N = r[MSB]; Z = (r==0).
  - Logical ops, MOV, MVN, MUL: N and Z are updated; C and V hold their previous value.
  - sr is written only when s_bit=1, on the same edge the result is registered.
  - ADC/SBC read C from sr as it was before that edge.
- Handshake:
  - Accept occurs on an edge where in_valid & in_ready.
  - in_ready = (state==IDLE) & (!out_valid | out_ready).
  - Result delivery occurs on an edge where out_valid & out_ready. out_valid clears unless a new result is registered on the same edge.
  - alu_out and sr stay stable while out_valid=1 and out_ready=0.
- State machine: IDLE, MUL_BUSY.
  - IDLE, non-MUL accept at edge t: result registered at edge t, out_valid=1 from edge t (latency 1). Back-to-back accepts give throughput 1/cycle.
  - IDLE, MUL accept at edge t: latch operands and s_bit, acc=0, counter=WIDTH, go to MUL_BUSY, in_ready=0.
  - MUL_BUSY, each edge:
    - if mcand_lsb, acc += mplier_shifted; shift; counter−1.
    - When counter reaches 0 (edge t+WIDTH): register acc, out_valid=1, update N/Z if s_bit, return to IDLE.
  - Output register is guaranteed empty on MUL completion (in_ready required it at accept).
- Simultaneous delivery and accept on one edge: the old result is consumed and the new result is registered (no bubble).
- in_valid while in_ready=0 is ignored. Operands need not be held after the accept edge.

Decomposition:
- Package alu_pkg:
  - 4-bit command localparams (MOV…MUL).
  - Flag bit indices Z=3, C=2, N=1, V=0.
  - State enum {IDLE, MUL_BUSY}.
- Sub-module alu_comb: purely combinational; WIDTH parameter; inputs cmd, val1, val2, c_in; outputs result, nzcv_next. Covers all single-cycle ops.
- alu_seq holds the FSM, multiplier datapath, result/status registers and handshake.

Test Plan (WIDTH=32):
- ADD with s_bit=1, 0x7FFFFFFF+0x00000001 → alu_out=0x80000000 one edge after accept; sr={Z0,C0,N1,V1}.
- SUB 3−5 (s_bit=1), then ADC 1+1 back-to-back → first: 0xFFFFFFFE, C=0, N=1; second: 0x00000002 (C=0 consumed), in_ready stays 1.
- AND 0xF0F0F0F0 & 0x0F0F0F0F with s_bit=1, prior C=1 V=1 → alu_out=0, sr={1,1,0,1}.
- MUL 0x00010000×0x00010001, s_bit=1 → in_ready=0 for 32 cycles; out_valid after edge t+32; alu_out=0x00010000, Z=0.
- Backpressure: hold out_ready=0 after ADD result → in_ready=0, alu_out/sr stable for 5 cycles; assert out_ready together with in_valid (MOV 0x55) → ADD delivered, MOV registered on the same edge.
- rst_n low mid-MUL (cycle 10) → out_valid=0, sr=0 immediately (asynchronously); after release, in_ready=1 and the next ADD 2+2 gives 4.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared command codes, status-flag bit positions and FSM states for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    // Status register layout is {Z,C,N,V}.
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result handshake bundle between the ID/EX and EX/MEM stages.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_cmd;
    logic             s_bit;
    logic [WIDTH-1:0] val1;
    logic [WIDTH-1:0] val2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic [3:0]       sr;

    modport master (
        output in_valid, alu_cmd, s_bit, val1, val2, out_ready,
        input  in_ready, out_valid, alu_out, sr
    );

    modport slave (
        input  in_valid, alu_cmd, s_bit, val1, val2, out_ready,
        output in_ready, out_valid, alu_out, sr
    );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: result and next {Z,C,N,V} for every non-multiply command.
// Purely combinational; C/V pass through unchanged for non-arithmetic commands.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       cmd_i,
    input  logic [WIDTH-1:0] val1_i,
    input  logic [WIDTH-1:0] val2_i,
    input  logic             c_in_i,
    input  logic             v_in_i,
    output logic [WIDTH-1:0] result_o,
    output logic [3:0]       nzcv_next_o
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             c_out;
    logic             v_out;

    always_comb begin
        sum   = '0;
        res   = '0;
        c_out = c_in_i;
        v_out = v_in_i;
        unique case (cmd_i)
            CMD_MOV: res = val2_i;
            CMD_MVN: res = ~val2_i;
            CMD_AND: res = val1_i & val2_i;
            CMD_ORR: res = val1_i | val2_i;
            CMD_EOR: res = val1_i ^ val2_i;
            CMD_ADD, CMD_ADC: begin
                sum   = {1'b0, val1_i} + {1'b0, val2_i}
                      + {{WIDTH{1'b0}}, (cmd_i == CMD_ADC) ? c_in_i : 1'b0};
                res   = sum[MSB:0];
                c_out = sum[WIDTH];
                v_out = (val1_i[MSB] == val2_i[MSB]) & (res[MSB] != val1_i[MSB]);
            end
            // Subtract as a + ~b + carry, so the carry out is already NOT borrow.
            CMD_SUB, CMD_SBC: begin
                sum   = {1'b0, val1_i} + {1'b0, ~val2_i}
                      + {{WIDTH{1'b0}}, (cmd_i == CMD_SBC) ? c_in_i : 1'b1};
                res   = sum[MSB:0];
                c_out = sum[WIDTH];
                v_out = (val1_i[MSB] != val2_i[MSB]) & (res[MSB] != val1_i[MSB]);
            end
            default: res = '0;
        endcase
        result_o            = res;
        nzcv_next_o         = '0;
        nzcv_next_o[FLAG_Z] = (res == '0);
        nzcv_next_o[FLAG_C] = c_out;
        nzcv_next_o[FLAG_N] = res[MSB];
        nzcv_next_o[FLAG_V] = v_out;
    end

endmodule

// File: rtl/alu_seq.sv
// Registered execute-stage ALU with NZCV status register and iterative shift-add multiplier.
// Latency 1 cycle (WIDTH cycles for MUL); input stalls while multiplying or while an undelivered result is held.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic       clk,
    input logic       rst_n,
    alu_seq_if.slave  bus
);
    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [3:0]       sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             mul_s_q, mul_s_d;

    logic             in_ready;
    logic             accept;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] comb_result;
    logic [3:0]       comb_nzcv;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .cmd_i       (bus.alu_cmd),
        .val1_i      (bus.val1),
        .val2_i      (bus.val2),
        .c_in_i      (sr_q[FLAG_C]),
        .v_in_i      (sr_q[FLAG_V]),
        .result_o    (comb_result),
        .nzcv_next_o (comb_nzcv)
    );

    assign in_ready = rst_n & (state_q == IDLE) & (~out_valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;
    assign acc_sum  = acc_q + (mcand_q[0] ? mplier_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        alu_out_d   = alu_out_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        mul_s_d     = mul_s_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.alu_cmd == CMD_MUL) begin
                        mplier_d = bus.val1;
                        mcand_d  = bus.val2;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        mul_s_d  = bus.s_bit;
                        state_d  = MUL_BUSY;
                    end else begin
                        alu_out_d   = comb_result;
                        out_valid_d = 1'b1;
                        if (bus.s_bit) sr_d = comb_nzcv;
                    end
                end
            end
            MUL_BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q >> 1;
                mplier_d = mplier_q << 1;
                cnt_d    = cnt_q - CNT_W'(1);
                // Final iteration: the output register was emptied before this multiply was accepted.
                if (cnt_q == CNT_W'(1)) begin
                    alu_out_d   = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    if (mul_s_q) begin
                        sr_d[FLAG_Z] = (acc_sum == '0);
                        sr_d[FLAG_N] = acc_sum[WIDTH-1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mul_s_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            mul_s_q     <= mul_s_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.sr        = sr_q;

endmodule
